// File: rtl/serial_frame_rx.sv
// serial_frame_rx: oversampling receiver for an idle-high asynchronous serial line.
// Detects start bits with glitch rejection, shifts in LSB-first data frames,
// checks the stop bit and presents each good word on a single-entry
// valid/ready output register.
// Optional feature macro: PARITY_EN adds one even-parity bit between the last
// data bit and the stop bit and enables parity_err. When it is undefined,
// parity_err is tied low.
module serial_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef PARITY_EN
    // Even parity: the transmitted parity bit equals the XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    state_t            state_r, state_next_s;
    logic              sync1_r, rxs_r, rxs_d_r;
    logic [CNT_W-1:0]  clk_cnt_r, clk_cnt_next_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_next_s;
    logic [DATA_W-1:0] shift_r, shift_next_s;
    logic [DATA_W-1:0] m_data_r, m_data_next_s;
    logic              m_valid_r, m_valid_next_s;
    logic              frame_err_r, frame_err_next_s;
    logic              overrun_r, overrun_next_s;
    logic              accept_s;
`ifdef PARITY_EN
    logic              par_bad_r, par_bad_next_s;
    logic              parity_err_r, parity_err_next_s;
`endif

    assign accept_s = m_valid_r && m_ready;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            rxs_d_r <= 1'b1;
        end else begin
            sync1_r <= rx_i;
            rxs_r   <= sync1_r;
            rxs_d_r <= rxs_r;
        end
    end

    // State register together with the receive datapath and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            clk_cnt_r    <= {CNT_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            shift_r      <= {DATA_W{1'b0}};
            m_data_r     <= {DATA_W{1'b0}};
            m_valid_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
`ifdef PARITY_EN
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_next_s;
            clk_cnt_r    <= clk_cnt_next_s;
            bit_cnt_r    <= bit_cnt_next_s;
            shift_r      <= shift_next_s;
            m_data_r     <= m_data_next_s;
            m_valid_r    <= m_valid_next_s;
            frame_err_r  <= frame_err_next_s;
            overrun_r    <= overrun_next_s;
`ifdef PARITY_EN
            par_bad_r    <= par_bad_next_s;
            parity_err_r <= parity_err_next_s;
`endif
        end
    end

    // Next-state, bit sampling, stop-bit checks and output-register update.
    always_comb begin
        state_next_s      = state_r;
        clk_cnt_next_s    = clk_cnt_r;
        bit_cnt_next_s    = bit_cnt_r;
        shift_next_s      = shift_r;
        m_data_next_s     = m_data_r;
        frame_err_next_s  = 1'b0;
        overrun_next_s    = 1'b0;
`ifdef PARITY_EN
        par_bad_next_s    = par_bad_r;
        parity_err_next_s = 1'b0;
`endif
        // A consumed word frees the register unless a new one loads below.
        if (accept_s) begin
            m_valid_next_s = 1'b0;
        end else begin
            m_valid_next_s = m_valid_r;
        end

        case (state_r)
            S_IDLE: begin
                clk_cnt_next_s = {CNT_W{1'b0}};
                bit_cnt_next_s = {BIT_W{1'b0}};
`ifdef PARITY_EN
                par_bad_next_s = 1'b0;
`endif
                if (rxs_d_r && !rxs_r) begin
                    state_next_s = S_START;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_START: begin
                if (clk_cnt_r == HALF_LAST) begin
                    clk_cnt_next_s = {CNT_W{1'b0}};
                    bit_cnt_next_s = {BIT_W{1'b0}};
                    // Still low at mid-bit: a real start bit; otherwise a glitch.
                    if (!rxs_r) begin
                        state_next_s = S_DATA;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_next_s               = {CNT_W{1'b0}};
                    shift_next_s                 = shift_r >> 1;
                    shift_next_s[DATA_W-1]       = rxs_r;
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_next_s = {BIT_W{1'b0}};
`ifdef PARITY_EN
                        state_next_s   = S_PARITY;
`else
                        state_next_s   = S_STOP;
`endif
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 1'b1;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + 1'b1;
                end
            end
            S_PARITY: begin
`ifdef PARITY_EN
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_next_s = {CNT_W{1'b0}};
                    par_bad_next_s = (rxs_r != even_parity(shift_r));
                    state_next_s   = S_STOP;
                end else begin
                    clk_cnt_next_s = clk_cnt_r + 1'b1;
                end
`else
                state_next_s = S_IDLE;
`endif
            end
            S_STOP: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_next_s = {CNT_W{1'b0}};
                    state_next_s   = S_IDLE;
                    if (!rxs_r) begin
                        frame_err_next_s = 1'b1;
`ifdef PARITY_EN
                    end else if (par_bad_r) begin
                        parity_err_next_s = 1'b1;
`endif
                    end else if (!m_valid_r || accept_s) begin
                        m_data_next_s  = shift_r;
                        m_valid_next_s = 1'b1;
                    end else begin
                        // Register still full: keep the old word, drop the new one.
                        overrun_next_s = 1'b1;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + 1'b1;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
`ifdef PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (DATA_W=8, CLKS_PER_BIT=16).
// Honors PARITY_EN the same way as the design.
module tb_serial_frame_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters maintained by the monitor.
    int fe_n = 0, pe_n = 0, ov_n = 0, acc_n = 0, mv_n = 0;
    logic [7:0] acc_data = 8'h00;
    int b_fe, b_pe, b_ov, b_acc, b_mv;

    serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: counts pulse cycles and accepted words away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err)  fe_n  = fe_n + 1;
            if (parity_err) pe_n  = pe_n + 1;
            if (overrun)    ov_n  = ov_n + 1;
            if (m_valid)    mv_n  = mv_n + 1;
            if (m_valid && m_ready) begin
                acc_n    = acc_n + 1;
                acc_data = m_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_fe = fe_n; b_pe = pe_n; b_ov = ov_n; b_acc = acc_n; b_mv = mv_n;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rx_i = b;
        cycles(CPB);
    endtask

    // Full frame with explicit stop and parity bits, then a short idle gap.
    task automatic send_raw(input logic [7:0] d, input logic stop_b, input logic par_b);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef PARITY_EN
        bit_out(par_b);
`else
        if (par_b) begin end
`endif
        bit_out(stop_b);
        rx_i = 1'b1;
        cycles(4);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b);
        send_raw(d, stop_b, ^d);
    endtask

    initial begin
        rst     = 1'b1;
        rx_i    = 1'b1;
        m_ready = 1'b1;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_m_valid",    {31'd0, m_valid},    32'd0);
        chk("reset_m_data",     {24'd0, m_data},     32'd0);
        chk("reset_frame_err",  {31'd0, frame_err},  32'd0);
        chk("reset_parity_err", {31'd0, parity_err}, 32'd0);
        chk("reset_overrun",    {31'd0, overrun},    32'd0);
        cycles(4);

        // Good frame 0xA5 with the consumer ready: one-cycle valid, no pulses.
        snap();
        send(8'hA5, 1'b1);
        chk("a5_accepts",  acc_n - b_acc, 1);
        chk("a5_valid_cyc", mv_n - b_mv, 1);
        chk("a5_data",     {24'd0, acc_data}, 32'h0000_00A5);
        chk("a5_fe",       fe_n - b_fe, 0);
        chk("a5_pe",       pe_n - b_pe, 0);
        chk("a5_ov",       ov_n - b_ov, 0);

        // Short low glitch in IDLE is rejected; the next frame still arrives.
        snap();
        rx_i = 1'b0;
        cycles(4);
        rx_i = 1'b1;
        cycles(3 * CPB);
        chk("glitch_valid", mv_n - b_mv, 0);
        chk("glitch_pulses", (fe_n - b_fe) + (pe_n - b_pe) + (ov_n - b_ov), 0);
        send(8'h3C, 1'b1);
        chk("post_glitch_accepts", acc_n - b_acc, 1);
        chk("post_glitch_data", {24'd0, acc_data}, 32'h0000_003C);

        // Stop bit low: one-cycle frame_err, no word.
        snap();
        send(8'h3C, 1'b0);
        cycles(CPB);
        chk("ferr_pulse_cycles", fe_n - b_fe, 1);
        chk("ferr_valid", mv_n - b_mv, 0);
        chk("ferr_pe", pe_n - b_pe, 0);

        // Consumer stalled: first word held, second dropped with overrun.
        m_ready = 1'b0;
        snap();
        send(8'h11, 1'b1);
        @(negedge clk);
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data",  {24'd0, m_data}, 32'h0000_0011);
        send(8'h22, 1'b1);
        @(negedge clk);
        chk("ovr_pulse_cycles", ov_n - b_ov, 1);
        chk("ovr_old_data", {24'd0, m_data}, 32'h0000_0011);
        chk("ovr_valid", {31'd0, m_valid}, 32'd1);
        chk("ovr_fe", fe_n - b_fe, 0);
        cycles(1);
        m_ready = 1'b1;
        cycles(1);
        m_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", {31'd0, m_valid}, 32'd0);
        chk("drain_accepts", acc_n - b_acc, 1);
        chk("drain_data", {24'd0, acc_data}, 32'h0000_0011);
        cycles(2 * CPB);
        chk("no_0x22_valid", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b1;

`ifdef PARITY_EN
        // Wrong parity bit: parity_err, no word; then correct parity delivers.
        snap();
        send_raw(8'h07, 1'b1, 1'b0);
        chk("perr_pulse_cycles", pe_n - b_pe, 1);
        chk("perr_valid", mv_n - b_mv, 0);
        chk("perr_fe", fe_n - b_fe, 0);
        send_raw(8'h07, 1'b1, 1'b1);
        chk("par_ok_accepts", acc_n - b_acc, 1);
        chk("par_ok_data", {24'd0, acc_data}, 32'h0000_0007);
        chk("par_ok_pe", pe_n - b_pe, 1);
`endif

        // Load a held word, then reset during data bit 4 of another frame.
        m_ready = 1'b0;
        send(8'h33, 1'b1);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        cycles(1);
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        rx_i = 1'b0;
        cycles(CPB / 2);
        rst  = 1'b1;
        rx_i = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid",   {31'd0, m_valid},   32'd0);
        chk("rst_mid_data",    {24'd0, m_data},    32'd0);
        chk("rst_mid_ferr",    {31'd0, frame_err}, 32'd0);
        chk("rst_mid_overrun", {31'd0, overrun},   32'd0);
        chk("rst_mid_perr",    {31'd0, parity_err}, 32'd0);
        m_ready = 1'b1;
        cycles(2 * CPB);
        snap();
        send(8'h5A, 1'b1);
        chk("after_rst_accepts", acc_n - b_acc, 1);
        chk("after_rst_data", {24'd0, acc_data}, 32'h0000_005A);
        chk("after_rst_pulses", (fe_n - b_fe) + (pe_n - b_pe) + (ov_n - b_ov), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receive side of the team's asynchronous serial test link. Oversamples a single idle-high serial line and detects start bits with glitch rejection. Shifts in LSB-first data frames, checks the stop bit (and optional parity), and presents each good word on a single-entry valid/ready output register. Sits at the leaf of a generated test hierarchy, paired with the serializer that drives the same line.

## Interface
Parameters:
- DATA_W, default 8: data bits per frame, 1..16.
- CLKS_PER_BIT, default 16: clk cycles per serial bit, even, at least 4.

Ports:
- clk  input  1  — the block's single clock.
- rst  input  1  — reset, synchronous and active-high.
- rx_i  input  1  — serial line, idle high, asynchronous to clk.
- m_data  output  DATA_W  — received word.
- m_valid  output  1  — m_data holds an unconsumed word.
- m_ready  input  1  — consumer accepts the word when m_valid && m_ready.
- frame_err  output  1  — 1-cycle pulse: stop bit sampled low.
- parity_err  output  1  — 1-cycle pulse: parity mismatch.
- overrun  output  1  — 1-cycle pulse: good frame dropped because the output register was still full.

## Operation
- rx_i passes through a 2-flop synchronizer, reset to 1. All logic below uses the synchronized value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a high-to-low transition on rxs moves to START and clears the bit counter.
- START: after CLKS_PER_BIT/2 cycles, sample rxs.
  - Low: go to DATA with the bit counter reset.
  - High: glitch; return to IDLE with no outputs.
- DATA: sample every CLKS_PER_BIT cycles from the mid-start point. Shift LSB-first into the shift register. After DATA_W samples go to PARITY (macro defined) or STOP.
- PARITY: sample one bit. Even parity: the expected bit equals the XOR of the data bits. Store the mismatch.
- STOP: sample one bit, then return to IDLE. Checks apply in this priority order:
  - Stop bit 0: pulse frame_err and discard the word. parity_err is not pulsed.
  - Otherwise, parity mismatch: pulse parity_err and discard the word.
  - Otherwise, if the output register is empty, or is being accepted this cycle (m_valid && m_ready): load m_data and set m_valid.
  - Otherwise: pulse overrun and drop the new word. The old word is retained unchanged.
- m_valid clears on m_valid && m_ready unless a new word loads in the same cycle. A simultaneous accept and load results in m_valid staying 1 with the new data and no overrun.
- m_data is stable while m_valid=1 and m_ready=0.
- IDLE is re-entered directly after the stop sample. A new falling edge can start the next frame immediately.

## Timing
- Reset: state IDLE, counters 0, synchronizer 1, m_data=0, m_valid=0, frame_err=0, parity_err=0, overrun=0.
- Reset asserted mid-frame aborts the frame with no error pulse. Any word held in the output register is lost.
- Input latency: 2 cycles from rx_i to rxs.
- Sample points: start at edge+CLKS_PER_BIT/2, then each following bit at +CLKS_PER_BIT.
- m_valid rises, or an error/overrun pulse appears, on the cycle after the stop-bit sample.
- Error and overrun pulses last exactly 1 cycle. At most one pulse fires per frame.
- Throughput: one frame per (DATA_W+2[+1])·CLKS_PER_BIT cycles, back-to-back.

## Configuration
- PARITY_EN defined:
  - One even-parity bit is expected between the last data bit and the stop bit.
  - parity_err is active.
- PARITY_EN undefined:
  - There is no parity bit; the frame is start + DATA_W data bits + stop.
  - The PARITY state is unreachable and parity_err is tied 0.

## Test plan
(DATA_W=8, CLKS_PER_BIT=16)
- Send 0xA5 with a valid stop bit, m_ready=1: m_valid high 1 cycle with m_data=0xA5; no error pulses.
- Drive rx_i low for 4 cycles in IDLE, then high: no m_valid and no pulses; the next frame 0x3C is received correctly.
- Send 0x3C with the stop bit low: frame_err pulses 1 cycle; m_valid stays 0.
- m_ready=0, send 0x11 then 0x22:
  - m_data=0x11 with m_valid=1.
  - overrun pulses at the end of the 0x22 frame.
  - Raising m_ready then consumes 0x11 and m_valid drops; 0x22 is never presented.
- With PARITY_EN defined, send 0x07 with parity bit 0 (correct bit is 1): parity_err pulses; m_valid stays 0. Resending with parity bit 1 yields m_data=0x07.
- Assert rst for 1 cycle during DATA bit 4: all outputs are 0 the next cycle; a following frame 0x5A delivers m_data=0x5A.
